laser_controller: RTL and testbench
===================================

# laser_controller

Sequencer for the laser beam layer: accepts a fire request from game logic and drives the beam's `laser_active`, `laser_r` and `laser_quadrant` inputs frame-by-frame. It latches the firing quadrant and sweeps the beam radius outward once per configured number of frames. It emits a hit-check strobe when the sweep completes, then enforces a cooldown before the next shot. It sits between the game FSM / input decoder and the per-quadrant laser layers. All layer-facing outputs change only on frame boundaries, so no beam tears mid-frame.

## Interface
Parameters:
- `FRAMES_PER_STEP`, 2, frames per `laser_r` increment; legal range 1..15.
- `COOLDOWN_FRAMES`, 30, frames between end of a shot and readiness; legal range 1..255.

Ports:
- `clk` input 1: system clock (single clock domain).
- `rst_n` input 1: synchronous, active-low reset.
- `frame_tick` input 1: one-cycle pulse at start of vertical blank.
- `fire` input 1: fire request, sampled every cycle.
- `fire_quadrant` input 2: quadrant requested with `fire`.
- `laser_clear` input 1: synchronous abort (game over / level reset).
- `fire_ack` output 1: one-cycle pulse when a request is accepted.
- `laser_active` output 1: beam visible.
- `laser_r` output 4: beam sweep step, 0..15.
- `laser_quadrant` output 2: latched quadrant of the current shot.
- `hit_strobe` output 1: one-cycle pulse when the sweep completes; collision logic evaluates hits on this pulse.
- `ready` output 1: high only in IDLE.

## Operation
- States: IDLE, ARMED, FIRING, COOLDOWN.
- IDLE: `ready`=1. If `fire`=1, the block:
  - latches `fire_quadrant` into `laser_quadrant`;
  - pulses `fire_ack`;
  - moves to ARMED.
- ARMED: waits for `frame_tick`. On `frame_tick` it sets `laser_active`=1, `laser_r`=0 and step counter=0, then moves to FIRING.
- FIRING: on each `frame_tick` the step counter increments.
  - When the counter reaches `FRAMES_PER_STEP`-1 on a tick, the counter clears and `laser_r` increments.
  - When `laser_r`=15 and the step counter completes, the block pulses `hit_strobe`, clears `laser_active` and sets `laser_r`=0.
  - It then moves to COOLDOWN (cooldown counter=0) or, when cooldown is compiled out, to IDLE.
- COOLDOWN: each `frame_tick` increments the cooldown counter. On the tick where the counter equals `COOLDOWN_FRAMES`-1, the block moves to IDLE.
- `fire` outside IDLE is ignored: no ack, not queued.
- `laser_quadrant` holds its value until the next accepted fire, including through COOLDOWN and IDLE.
- `laser_clear`=1 from any state: next state is IDLE, `laser_active`=0, `laser_r`=0, counters=0, no `hit_strobe`, no `fire_ack`. `laser_clear` has priority over `fire` and `frame_tick`.
- Counters: step counter is 4 bits, cooldown counter is 8 bits. Compare with equality, never wrap.
- Shot duration: exactly 16×`FRAMES_PER_STEP` frames of `laser_active`.

## Timing
- All outputs registered. A condition sampled at edge N is visible after edge N.
- Reset values (`rst_n`=0 at an edge): state IDLE, `fire_ack`=0, `laser_active`=0, `laser_r`=0, `laser_quadrant`=0, `hit_strobe`=0, `ready`=1, counters=0. Reset mid-shot aborts identically to `laser_clear`.
- Acceptance latency: `fire_ack` and `ready`=0 one cycle after `fire` is sampled.
- `fire` and `frame_tick` high in the same IDLE cycle: accept to ARMED. Activation waits for the next `frame_tick`; it never activates on the same tick.
- `laser_active`, `laser_r` and `hit_strobe` transition only one cycle after a `frame_tick` edge.
- `hit_strobe` coincides with the cycle `laser_active` falls.
- In COOLDOWN, `ready` rises one cycle after the final cooldown tick. With the default parameters, the earliest re-accept is 30 ticks after `hit_strobe`.

## Configuration
- `LASER_COOLDOWN_EN` defined: COOLDOWN state and 8-bit counter present, behaviour as above.
- `LASER_COOLDOWN_EN` undefined: COOLDOWN state and counter removed. FIRING completion goes directly to IDLE, and `ready` rises together with `hit_strobe`. `COOLDOWN_FRAMES` is unused.

## Test plan
- Reset, then `fire`=1 with `fire_quadrant`=2 for one cycle → `fire_ack` pulse, `laser_quadrant`=2, `laser_active` stays 0 until the next `frame_tick`, then rises with `laser_r`=0.
- Full sweep with defaults → `laser_r` steps 0..15, each value held 2 ticks; `laser_active` high for 32 ticks; a single `hit_strobe` as `laser_active` falls.
- With `LASER_COOLDOWN_EN`, `fire` held high after `hit_strobe` → no ack for 30 ticks; ack on the cycle after `ready` returns. Without the macro, ack comes one cycle after `hit_strobe`.
- `fire` with `fire_quadrant`=3 during FIRING → no `fire_ack`, `laser_quadrant` stays at its original value, sweep unaffected.
- `laser_clear` at `laser_r`=7 → next cycle IDLE, `laser_active`=0, `laser_r`=0, no `hit_strobe`. `laser_clear` together with `fire` in IDLE → no ack.
- `rst_n`=0 mid-COOLDOWN → all outputs at their reset values after one edge. `fire` and `frame_tick` together in IDLE → ARMED, activation on the following tick.

Source files
------------

// File: rtl/laser_controller.sv
// rtl/laser_controller.sv - laser beam shot sequencer (arm, sweep, hit strobe, cooldown)
//
// Purpose: accepts a fire request, latches the quadrant, sweeps laser_r 0..15
// advancing once every FRAMES_PER_STEP frame ticks, pulses hit_strobe when the
// sweep completes, then (optionally) waits COOLDOWN_FRAMES ticks before the
// next shot. Layer-facing outputs only move on the cycle after a frame_tick.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   frame_tick     in   one-cycle pulse at start of vertical blank
//   fire           in   fire request, sampled every cycle
//   fire_quadrant  in   [1:0] quadrant requested with fire
//   laser_clear    in   synchronous abort, highest priority after reset
//   fire_ack       out  one-cycle pulse when a request is accepted
//   laser_active   out  beam visible
//   laser_r        out  [3:0] beam sweep step
//   laser_quadrant out  [1:0] latched quadrant of the current shot
//   hit_strobe     out  one-cycle pulse when the sweep completes
//   ready          out  high only in IDLE
//
// Option: LASER_COOLDOWN_EN - when defined, adds the COOLDOWN state and its
// 8-bit frame counter; when undefined, sweep completion returns to IDLE.

module laser_controller #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [1:0] fire_quadrant,
  input  logic       laser_clear,
  output logic       fire_ack,
  output logic       laser_active,
  output logic [3:0] laser_r,
  output logic [1:0] laser_quadrant,
  output logic       hit_strobe,
  output logic       ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FIRING = 2'd2
`ifdef LASER_COOLDOWN_EN
    , COOLDOWN = 2'd3
`endif
  } state_e;

  localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);

  state_e     state_q;
  logic       fire_ack_q;
  logic       active_q;
  logic [3:0] r_q;
  logic [1:0] quad_q;
  logic       hit_q;
  logic       ready_q;
  logic [3:0] step_q;

`ifdef LASER_COOLDOWN_EN
  localparam logic [7:0] CD_LAST = 8'(COOLDOWN_FRAMES - 1);
  logic [7:0] cd_q;
`else
  logic unused_cooldown_cfg;
  assign unused_cooldown_cfg = (COOLDOWN_FRAMES != 0);
`endif

  always_ff @(posedge clk) begin
    // Reset and laser_clear share the abort path; only reset forgets the quadrant.
    if (!rst_n || laser_clear) begin
      state_q    <= IDLE;
      fire_ack_q <= 1'b0;
      active_q   <= 1'b0;
      r_q        <= 4'd0;
      hit_q      <= 1'b0;
      ready_q    <= 1'b1;
      step_q     <= 4'd0;
`ifdef LASER_COOLDOWN_EN
      cd_q       <= 8'd0;
`endif
      if (!rst_n) begin
        quad_q <= 2'd0;
      end
    end else begin
      fire_ack_q <= 1'b0;
      hit_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            quad_q     <= fire_quadrant;
            fire_ack_q <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= ARMED;
          end
        end
        ARMED: begin
          if (frame_tick) begin
            active_q <= 1'b1;
            r_q      <= 4'd0;
            step_q   <= 4'd0;
            state_q  <= FIRING;
          end
        end
        FIRING: begin
          if (frame_tick) begin
            if (step_q == STEP_LAST) begin
              step_q <= 4'd0;
              if (r_q == 4'd15) begin
                hit_q    <= 1'b1;
                active_q <= 1'b0;
                r_q      <= 4'd0;
`ifdef LASER_COOLDOWN_EN
                cd_q     <= 8'd0;
                state_q  <= COOLDOWN;
`else
                ready_q  <= 1'b1;
                state_q  <= IDLE;
`endif
              end else begin
                r_q <= r_q + 4'd1;
              end
            end else begin
              step_q <= step_q + 4'd1;
            end
          end
        end
`ifdef LASER_COOLDOWN_EN
        COOLDOWN: begin
          if (frame_tick) begin
            if (cd_q == CD_LAST) begin
              cd_q    <= 8'd0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              cd_q <= cd_q + 8'd1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign fire_ack       = fire_ack_q;
  assign laser_active   = active_q;
  assign laser_r        = r_q;
  assign laser_quadrant = quad_q;
  assign hit_strobe     = hit_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_laser_controller.sv
// tb/tb_laser_controller.sv - scoreboard bench for laser_controller
module tb_laser_controller;

  localparam int FPS = 2;
  localparam int CDF = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       fire;
  logic [1:0] fire_quadrant;
  logic       laser_clear;
  logic       fire_ack;
  logic       laser_active;
  logic [3:0] laser_r;
  logic [1:0] laser_quadrant;
  logic       hit_strobe;
  logic       ready;

  laser_controller #(
    .FRAMES_PER_STEP(FPS),
    .COOLDOWN_FRAMES(CDF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .fire_quadrant (fire_quadrant),
    .laser_clear   (laser_clear),
    .fire_ack      (fire_ack),
    .laser_active  (laser_active),
    .laser_r       (laser_r),
    .laser_quadrant(laser_quadrant),
    .hit_strobe    (hit_strobe),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  typedef enum int {S_ACK, S_ACT, S_R, S_QUAD, S_HIT, S_RDY} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef LASER_COOLDOWN_EN
  localparam int RDY_AT_HIT = 0;
`else
  localparam int RDY_AT_HIT = 1;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_ACK:   return {31'd0, fire_ack};
      S_ACT:   return {31'd0, laser_active};
      S_R:     return {28'd0, laser_r};
      S_QUAD:  return {30'd0, laser_quadrant};
      S_HIT:   return {31'd0, hit_strobe};
      default: return {31'd0, ready};
    endcase
  endfunction

  task automatic sb_push(input string tag, input sig_e sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Advance one clock edge, then pop and compare everything queued for it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, sample(e.sig), e.val);
    end
  endtask

  // Ticks numbered from activation; each followed by a quiet hold cycle.
  task automatic run_ticks(input int first_k, input int last_k);
    for (int k = first_k; k <= last_k; k++) begin
      frame_tick = 1'b1;
      sb_push($sformatf("sweep_act_k%0d", k), S_ACT, 1);
      sb_push($sformatf("sweep_r_k%0d", k), S_R, k / FPS);
      sb_push($sformatf("sweep_hit_k%0d", k), S_HIT, 0);
      step();
      frame_tick = 1'b0;
      sb_push($sformatf("hold_r_k%0d", k), S_R, k / FPS);
      sb_push($sformatf("hold_act_k%0d", k), S_ACT, 1);
      step();
    end
  endtask

  task automatic final_tick(input int quad);
    frame_tick = 1'b1;
    sb_push("end_act", S_ACT, 0);
    sb_push("end_r", S_R, 0);
    sb_push("end_hit", S_HIT, 1);
    sb_push("end_rdy", S_RDY, RDY_AT_HIT);
    sb_push("end_ack", S_ACK, 0);
    sb_push("end_quad", S_QUAD, quad);
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; fire = 1'b0;
    fire_quadrant = 2'd0; laser_clear = 1'b0;

    step();
    sb_push("rst_ack", S_ACK, 0);  sb_push("rst_act", S_ACT, 0);
    sb_push("rst_r", S_R, 0);      sb_push("rst_quad", S_QUAD, 0);
    sb_push("rst_hit", S_HIT, 0);  sb_push("rst_rdy", S_RDY, 1);
    step();
    rst_n = 1'b1;

    // Accept quadrant 2, beam stays dark until the next tick.
    fire = 1'b1; fire_quadrant = 2'd2;
    sb_push("acc_ack", S_ACK, 1); sb_push("acc_rdy", S_RDY, 0);
    sb_push("acc_quad", S_QUAD, 2); sb_push("acc_act", S_ACT, 0);
    step();
    fire = 1'b0; fire_quadrant = 2'd0;
    for (int i = 0; i < 3; i++) begin
      sb_push("armed_ack", S_ACK, 0); sb_push("armed_act", S_ACT, 0);
      step();
    end
    frame_tick = 1'b1;
    sb_push("activate_act", S_ACT, 1); sb_push("activate_r", S_R, 0);
    step();
    frame_tick = 1'b0;

    // Full sweep; fire held into the final tick must be ignored while FIRING.
    run_ticks(1, 16 * FPS - 1);
    fire = 1'b1; fire_quadrant = 2'd1;
    final_tick(2);

`ifdef LASER_COOLDOWN_EN
    sb_push("cd_ack0", S_ACK, 0); sb_push("cd_hit_single", S_HIT, 0);
    step();
    for (int t = 1; t <= CDF; t++) begin
      frame_tick = 1'b1;
      sb_push($sformatf("cd_ack_t%0d", t), S_ACK, 0);
      sb_push($sformatf("cd_rdy_t%0d", t), S_RDY, (t == CDF) ? 1 : 0);
      step();
      frame_tick = 1'b0;
      if (t < CDF) begin
        sb_push($sformatf("cd_gap_ack_t%0d", t), S_ACK, 0);
        step();
      end
    end
`endif
    sb_push("reacc_ack", S_ACK, 1); sb_push("reacc_quad", S_QUAD, 1);
    sb_push("reacc_rdy", S_RDY, 0); sb_push("reacc_hit", S_HIT, 0);
    step();
    fire = 1'b0;

    frame_tick = 1'b1;
    sb_push("act2_act", S_ACT, 1); sb_push("act2_r", S_R, 0);
    step();
    frame_tick = 1'b0;
    run_ticks(1, 5);

    // Fire during FIRING: ignored, quadrant kept.
    fire = 1'b1; fire_quadrant = 2'd3;
    sb_push("ign_ack", S_ACK, 0); sb_push("ign_quad", S_QUAD, 1);
    sb_push("ign_r", S_R, 2);
    step();
    fire = 1'b0;
    run_ticks(6, 14);

    // Abort at laser_r=7, clear wins over the simultaneous tick.
    laser_clear = 1'b1; frame_tick = 1'b1;
    sb_push("clr_act", S_ACT, 0); sb_push("clr_r", S_R, 0);
    sb_push("clr_hit", S_HIT, 0); sb_push("clr_rdy", S_RDY, 1);
    step();
    laser_clear = 1'b0; frame_tick = 1'b0;
    sb_push("post_clr_hit", S_HIT, 0); sb_push("post_clr_act", S_ACT, 0);
    step();

    // Clear together with fire in IDLE: no ack.
    laser_clear = 1'b1; fire = 1'b1; fire_quadrant = 2'd2;
    sb_push("clrfire_ack", S_ACK, 0); sb_push("clrfire_rdy", S_RDY, 1);
    sb_push("clrfire_quad", S_QUAD, 1);
    step();
    laser_clear = 1'b0; fire = 1'b0;

    // Fire with tick in IDLE: armed only, activates on the following tick.
    fire = 1'b1; fire_quadrant = 2'd3; frame_tick = 1'b1;
    sb_push("ft_ack", S_ACK, 1); sb_push("ft_quad", S_QUAD, 3);
    sb_push("ft_act", S_ACT, 0); sb_push("ft_rdy", S_RDY, 0);
    step();
    fire = 1'b0; frame_tick = 1'b0;
    sb_push("ft_wait_act", S_ACT, 0);
    step();
    frame_tick = 1'b1;
    sb_push("ft_act_on", S_ACT, 1); sb_push("ft_r0", S_R, 0);
    step();
    frame_tick = 1'b0;
    run_ticks(1, 16 * FPS - 1);
    fire_quadrant = 2'd0;
    final_tick(3);

`ifdef LASER_COOLDOWN_EN
    for (int t = 0; t < 2; t++) begin
      frame_tick = 1'b1;
      sb_push("cd2_rdy", S_RDY, 0);
      step();
      frame_tick = 1'b0;
    end
`endif

    // Reset mid-cooldown (or idle when cooldown is compiled out).
    rst_n = 1'b0;
    sb_push("rst2_ack", S_ACK, 0);  sb_push("rst2_act", S_ACT, 0);
    sb_push("rst2_r", S_R, 0);      sb_push("rst2_quad", S_QUAD, 0);
    sb_push("rst2_hit", S_HIT, 0);  sb_push("rst2_rdy", S_RDY, 1);
    step();
    rst_n = 1'b1;
    sb_push("rst2_idle_rdy", S_RDY, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
